// File: rtl/fetch_align_if.sv
// rtl/fetch_align_if.sv - fetch/decode handshake bundle for the halfword aligner
interface fetch_align_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_error;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_error;

  modport master (
    output fetch_valid, fetch_addr, fetch_data, fetch_error,
    output redirect, redirect_addr, instr_ready,
    input  fetch_ready, instr_valid, instr_data, instr_pc,
    input  instr_compressed, instr_error
  );

  modport slave (
    input  fetch_valid, fetch_addr, fetch_data, fetch_error,
    input  redirect, redirect_addr, instr_ready,
    output fetch_ready, instr_valid, instr_data, instr_pc,
    output instr_compressed, instr_error
  );
endinterface

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - halfword instruction aligner between fetch port and decode
// COMPRESS_EN defined: 3-halfword buffer with RVC support; undefined: one word per instruction.
module fetch_align (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_align_if.slave  io_bus
);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FAULT = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_head_pc;
  logic [31:0] r_fetch_pc;
  logic        w_valid;
  logic        w_fire;
  logic        w_match;
  logic        w_pop;
  logic        w_unused;

  assign w_unused = ^{io_bus.fetch_addr[1:0], io_bus.redirect_addr[0]};
  assign w_fire   = io_bus.fetch_valid && io_bus.fetch_ready;
  assign w_match  = w_fire && (r_state == S_RUN) &&
                    (io_bus.fetch_addr[31:2] == r_fetch_pc[31:2]);
  assign w_pop    = w_valid && io_bus.instr_ready;

`ifdef COMPRESS_EN
  logic [15:0] r_hw [3];
  logic [2:0]  r_he;
  logic [1:0]  r_count;
  logic        r_skip;
  logic        w_h0_full;
  logic        w_len2;
  logic        w_err_out;
  logic [1:0]  w_popn;
  logic [1:0]  w_rem;
  logic [15:0] w_hw [3];
  logic [2:0]  w_he;
  logic [1:0]  w_count;

  // A faulted head halfword is emitted alone regardless of its length bits.
  assign w_h0_full = (r_hw[0][1:0] == 2'b11);
  assign w_len2    = w_h0_full && !r_he[0];
  assign w_valid   = (r_state == S_RUN) && (r_count != 2'd0) &&
                     (!w_len2 || (r_count >= 2'd2));
  assign w_err_out = r_he[0] || (w_len2 && r_he[1]);

  assign io_bus.fetch_ready      = (r_state == S_FAULT) || (r_count <= 2'd1);
  assign io_bus.instr_valid      = w_valid;
  assign io_bus.instr_data       = (!w_valid || r_he[0]) ? 32'h0 :
                                   (w_len2 ? {r_hw[1], r_hw[0]} : {16'h0, r_hw[0]});
  assign io_bus.instr_pc         = w_valid ? r_head_pc : 32'h0;
  assign io_bus.instr_compressed = w_valid && !w_h0_full && !r_he[0];
  assign io_bus.instr_error      = w_valid && w_err_out;

  always_comb begin
    w_popn = w_pop ? (w_len2 ? 2'd2 : 2'd1) : 2'd0;
    w_rem  = r_count - w_popn;
    for (int i = 0; i < 3; i++) w_hw[i] = 16'h0;
    w_he   = 3'b000;
    case (w_popn)
      2'd1: begin
        w_hw[0]   = r_hw[1];
        w_hw[1]   = r_hw[2];
        w_he[1:0] = r_he[2:1];
      end
      2'd2: begin
        w_hw[0] = r_hw[2];
        w_he[0] = r_he[2];
      end
      default: begin
        w_hw = r_hw;
        w_he = r_he;
      end
    endcase
    w_count = w_rem;
    // Appends land right after the survivors; a push needs count<=1 so w_rem<=1.
    if (w_match) begin
      if (r_skip) begin
        w_hw[w_rem] = io_bus.fetch_data[31:16];
        w_he[w_rem] = io_bus.fetch_error;
        w_count     = w_rem + 2'd1;
      end else begin
        w_hw[w_rem]         = io_bus.fetch_data[15:0];
        w_he[w_rem]         = io_bus.fetch_error;
        w_hw[w_rem + 2'd1]  = io_bus.fetch_data[31:16];
        w_he[w_rem + 2'd1]  = io_bus.fetch_error;
        w_count             = w_rem + 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_count    <= 2'd0;
      r_head_pc  <= 32'h0;
      r_fetch_pc <= 32'h0;
      r_skip     <= 1'b0;
      r_hw       <= '{default: 16'h0};
      r_he       <= 3'b000;
    end else if (io_bus.redirect) begin
      r_state    <= S_RUN;
      r_count    <= 2'd0;
      r_head_pc  <= {io_bus.redirect_addr[31:1], 1'b0};
      r_fetch_pc <= {io_bus.redirect_addr[31:2], 2'b00};
      r_skip     <= io_bus.redirect_addr[1];
    end else if (r_state == S_FAULT) begin
      r_count <= 2'd0;
    end else if (w_pop && w_err_out) begin
      r_state <= S_FAULT;
      r_count <= 2'd0;
    end else begin
      r_count <= w_count;
      r_hw    <= w_hw;
      r_he    <= w_he;
      if (w_pop) r_head_pc <= r_head_pc + {29'h0, w_popn, 1'b0};
      if (w_match) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_skip     <= 1'b0;
      end
    end
  end
`else
  logic [31:0] r_word;
  logic        r_werr;
  logic        r_full;

  assign w_valid = (r_state == S_RUN) && r_full;

  assign io_bus.fetch_ready      = (r_state == S_FAULT) || !r_full;
  assign io_bus.instr_valid      = w_valid;
  assign io_bus.instr_data       = (w_valid && !r_werr) ? r_word : 32'h0;
  assign io_bus.instr_pc         = w_valid ? r_head_pc : 32'h0;
  assign io_bus.instr_compressed = 1'b0;
  assign io_bus.instr_error      = w_valid && r_werr;

  // A halfword-aligned redirect target cannot be fetched as a word: emit a fault there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_head_pc  <= 32'h0;
      r_fetch_pc <= 32'h0;
      r_word     <= 32'h0;
      r_werr     <= 1'b0;
      r_full     <= 1'b0;
    end else if (io_bus.redirect) begin
      r_state    <= S_RUN;
      r_head_pc  <= {io_bus.redirect_addr[31:1], 1'b0};
      r_fetch_pc <= {io_bus.redirect_addr[31:2], 2'b00};
      r_word     <= 32'h0;
      r_werr     <= io_bus.redirect_addr[1];
      r_full     <= io_bus.redirect_addr[1];
    end else if (r_state == S_FAULT) begin
      r_full <= 1'b0;
    end else if (w_pop && r_werr) begin
      r_state <= S_FAULT;
      r_full  <= 1'b0;
    end else begin
      if (w_pop) r_full <= 1'b0;
      if (w_match) begin
        r_full     <= 1'b1;
        r_word     <= io_bus.fetch_data;
        r_werr     <= io_bus.fetch_error;
        r_head_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end
`endif
endmodule
